// File: rtl/code_fetch_ctrl.sv
// code_fetch_ctrl: fetches one big-endian instruction from byte-wide code memory per core request
// Ports: clk/rst (sync, active-high); fetch_req_i/fetch_pc_i/flush_i from the core;
// fetch_ack_o/fetch_instr_o/fetch_err_o/busy_o to the core;
// mem_cs_o/mem_addr_o to code memory, mem_rdy_i/mem_data_i from it.
module code_fetch_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_BYTES = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req_i,
  input  logic [ADDR_W-1:0]        fetch_pc_i,
  input  logic                     flush_i,
  output logic                     fetch_ack_o,
  output logic [8*INSTR_BYTES-1:0] fetch_instr_o,
  output logic                     fetch_err_o,
  output logic                     busy_o,
  output logic                     mem_cs_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_rdy_i,
  input  logic [7:0]               mem_data_i
);
  localparam int BW = 8 * (INSTR_BYTES - 1);
  localparam int CW = $clog2(INSTR_BYTES);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, DONE, DRAIN} state_t;
  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [TW-1:0]            tmo_q;
  logic [BW-1:0]            buf_q;
  logic                     low_q;
  logic                     ack_q, err_q, busy_q, cs_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [8*INSTR_BYTES-1:0] instr_q;
  wire tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      buf_q   <= '0;
      low_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      instr_q <= '0;
    end else begin
      cs_q  <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (!flush_i && fetch_req_i) begin
          addr_q  <= fetch_pc_i;
          cnt_q   <= '0;
          cs_q    <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          tmo_q   <= '0;
          low_q   <= 1'b0;
          state_q <= flush_i ? DRAIN : WAIT_LOW;
        end
        WAIT_LOW, WAIT_HIGH: begin
          tmo_q <= tmo_q + 1'b1;
          if (flush_i) begin
            // low phase already seen if we were past it or it is happening now
            low_q   <= state_q == WAIT_HIGH || !mem_rdy_i;
            state_q <= DRAIN;
          end else if (state_q == WAIT_LOW && !mem_rdy_i) begin
            state_q <= WAIT_HIGH;
          end else if (state_q == WAIT_HIGH && mem_rdy_i) begin
            buf_q <= BW'({buf_q, mem_data_i});
            if (cnt_q == CW'(INSTR_BYTES - 1)) begin
              instr_q <= {buf_q, mem_data_i};
              ack_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              addr_q  <= addr_q + 1'b1;
              cs_q    <= 1'b1;
              state_q <= ISSUE;
            end
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        DRAIN: begin
          tmo_q <= tmo_q + 1'b1;
          if ((low_q && mem_rdy_i) || tmo_hit) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!mem_rdy_i) begin
            low_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign fetch_ack_o   = ack_q;
  assign fetch_err_o   = err_q;
  assign fetch_instr_o = instr_q;
  assign busy_o        = busy_q;
  assign mem_cs_o      = cs_q;
  assign mem_addr_o    = addr_q;
endmodule

// File: tb/tb_code_fetch_ctrl.sv
// tb_code_fetch_ctrl: directed checks of code_fetch_ctrl against a simple cs/rdy memory model
module tb_code_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_pc = '0;
  logic        flush = 1'b0;
  logic        fetch_ack, fetch_err, busy, mem_cs;
  logic [31:0] fetch_instr;
  logic [7:0]  mem_addr;
  logic        mem_rdy = 1'b1;
  logic [7:0]  mem_data = '0;
  logic [7:0]  mem [256];
  logic        stuck = 1'b0;
  logic        ph = 1'b0;
  logic [7:0]  addr_l = '0;
  logic [7:0]  cs_a [1024];
  int          cs_n = 0;
  int          acks = 0;
  int          errs = 0;
  int          passed = 0;
  int          total = 0;
  code_fetch_ctrl dut (
    .clk(clk), .rst(rst), .fetch_req_i(fetch_req), .fetch_pc_i(fetch_pc), .flush_i(flush),
    .fetch_ack_o(fetch_ack), .fetch_instr_o(fetch_instr), .fetch_err_o(fetch_err), .busy_o(busy),
    .mem_cs_o(mem_cs), .mem_addr_o(mem_addr), .mem_rdy_i(mem_rdy), .mem_data_i(mem_data)
  );
  always #5 clk = ~clk;
  // rdy drops the cycle after cs and returns with data the cycle after that
  always @(posedge clk) begin
    if (stuck) begin
      mem_rdy <= 1'b1;
      ph      <= 1'b0;
    end else if (ph) begin
      mem_rdy  <= 1'b1;
      mem_data <= mem[addr_l];
      ph       <= 1'b0;
    end else if (mem_cs) begin
      mem_rdy <= 1'b0;
      addr_l  <= mem_addr;
      ph      <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (mem_cs) begin
      cs_a[cs_n % 1024] <= mem_addr;
      cs_n <= cs_n + 1;
    end
    if (fetch_ack) acks <= acks + 1;
    if (fetch_err) errs <= errs + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [7:0] pc, output int n);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    n = 0;
    do begin
      tick();
      fetch_req = 1'b0;
      n++;
    end while (!fetch_ack && !fetch_err && n < 60);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ack"},   32'(fetch_ack), 32'd0);
    chk({tag, "_err"},   32'(fetch_err), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_cs"},    32'(mem_cs), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_instr"}, fetch_instr, 32'd0);
  endtask
  initial begin
    int n, b, a0, e0;
    logic [7:0] e2 [4];
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[0] = 8'h40; mem[1] = 8'h10; mem[2] = 8'h00; mem[3] = 8'hB3;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB;
    tick(); tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();
    // 1: plain fetch at 0
    b = cs_n;
    fetch(8'h00, n);
    chk("t1_latency", 32'(n), 32'd13);
    chk("t1_ack", 32'(fetch_ack), 32'd1);
    chk("t1_instr", fetch_instr, 32'h401000B3);
    chk("t1_cs_count", 32'(cs_n - b), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_addr", 32'(cs_a[b + i]), 32'(i));
    tick();
    chk("t1_ack_pulse", 32'(fetch_ack), 32'd0);
    chk("t1_busy_after", 32'(busy), 32'd0);
    // 2: address wrap
    e2[0] = 8'hFE; e2[1] = 8'hFF; e2[2] = 8'h00; e2[3] = 8'h01;
    mem[0] = 8'hCC; mem[1] = 8'hDD;
    b = cs_n;
    fetch(8'hFE, n);
    chk("t2_latency", 32'(n), 32'd13);
    chk("t2_instr", fetch_instr, 32'hAABBCCDD);
    for (int i = 0; i < 4; i++) chk("t2_addr", 32'(cs_a[b + i]), 32'(e2[i]));
    mem[0] = 8'h40; mem[1] = 8'h10;
    tick();
    // 3: flush in WAIT_LOW after the second strobe
    b = cs_n; a0 = acks;
    fetch_req = 1'b1; fetch_pc = 8'h10;
    tick(); fetch_req = 1'b0;
    tick(); tick(); tick();
    chk("t3_second_cs", 32'(mem_cs), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_busy_drain", 32'(busy), 32'd1);
    tick();
    chk("t3_busy_fall", 32'(busy), 32'd0);
    tick(); tick();
    chk("t3_no_ack", 32'(acks - a0), 32'd0);
    chk("t3_cs_count", 32'(cs_n - b), 32'd2);
    chk("t3_instr_held", fetch_instr, 32'hAABBCCDD);
    fetch(8'h04, n);
    chk("t3_refetch_lat", 32'(n), 32'd13);
    chk("t3_refetch", fetch_instr, 32'h11223344);
    tick();
    // 4: memory never drops rdy -> timeout
    stuck = 1'b1;
    a0 = acks; e0 = errs;
    tick();
    fetch(8'h00, n);
    chk("t4_err_cycle", 32'(n), 32'd18);
    chk("t4_err", 32'(fetch_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(fetch_err), 32'd0);
    chk("t4_busy_next", 32'(busy), 32'd0);
    chk("t4_no_ack", 32'(acks - a0), 32'd0);
    chk("t4_err_count", 32'(errs - e0), 32'd1);
    chk("t4_instr_held", fetch_instr, 32'h11223344);
    stuck = 1'b0;
    tick(); tick();
    // 5: flush beats req in IDLE; req while busy is ignored
    b = cs_n; a0 = acks;
    fetch_req = 1'b1; flush = 1'b1; fetch_pc = 8'h04;
    tick();
    fetch_req = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("t5_no_cs", 32'(cs_n - b), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    fetch_req = 1'b1; fetch_pc = 8'h00;
    tick(); fetch_req = 1'b0;
    tick(); tick();
    fetch_req = 1'b1; fetch_pc = 8'h04;
    tick(); fetch_req = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("t5_one_ack", 32'(acks - a0), 32'd1);
    chk("t5_cs_count", 32'(cs_n - b), 32'd4);
    chk("t5_instr", fetch_instr, 32'h401000B3);
    // 6: reset during the third byte
    fetch_req = 1'b1; fetch_pc = 8'h04;
    tick(); fetch_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    chk_reset("t6");
    rst = 1'b0;
    tick(); tick();
    fetch(8'h00, n);
    chk("t6_latency", 32'(n), 32'd13);
    chk("t6_instr", fetch_instr, 32'h401000B3);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
